cpu6_muldiv: RTL and testbench



---
 rtl/cpu6_muldiv.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_cpu6_muldiv.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_muldiv.sv
// ============================================================================
// cpu6_muldiv -- iterative RV32M execute unit for the cpu6 EX stage.
//
// Decodes funct3 for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Multiply uses a radix-2 shift-add datapath. Divide uses a restoring datapath.
// Both run on operand magnitudes, and the sign is applied in a single FIX cycle.
//
// Handshake rules (both interfaces):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A request may only be taken in IDLE while flush is low.
//   In DONE, resp_valid stays high and resp_result/resp_rd hold steady until
//   the consumer raises resp_ready. The unit returns to IDLE on that edge.
//   flush aborts any state and discards the result.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/ready     request handshake
//   req_funct3          M-extension funct3
//   req_a, req_b        rs1 / rs2 operands
//   req_rd              destination tag carried to resp_rd
//   flush               abort in-flight operation (branch redirect/exception)
//   resp_valid/ready    response handshake
//   resp_result         result word
//   resp_rd             destination tag of the result
//   busy                state is not IDLE
//   dbg_state_o         current FSM state (IDLE=0, BUSY=1, FIX=2, DONE=3)
//
// Optional build macro: CPU6_MULDIV_EARLYOUT_EN
//   When defined, the unit finishes some requests in one cycle and goes
//   straight to DONE. These requests are divide-by-zero, signed divide
//   overflow, and multiply with a zero operand. Results are the same in
//   both builds.
// ============================================================================
module cpu6_muldiv #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic [RD_W-1:0] resp_rd,
    output logic            busy,
    output logic [1:0]      dbg_state_o
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              neg_q, neg_d;
    // hi_q: product high half (multiply) or partial remainder (divide).
    // lo_q: multiplier bits shifting out (multiply) or dividend in, quotient
    // out (divide).
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Request decode: signedness and magnitudes of the incoming operands
    // ------------------------------------------------------------------
    logic            req_is_div;
    logic            req_signed_a, req_signed_b;
    logic            req_sa, req_sb;
    logic [XLEN-1:0] req_a_abs, req_b_abs;
    logic            req_neg;
    logic            req_b_zero;

    assign req_is_div   = req_funct3[2];
    // DIV and REM are the signed divides; MUL counts as unsigned.
    assign req_signed_a = (req_funct3 == F3_MULH) || (req_funct3 == F3_MULHSU) ||
                          (req_is_div && !req_funct3[0]);
    assign req_signed_b = (req_funct3 == F3_MULH) ||
                          (req_is_div && !req_funct3[0]);
    assign req_sa       = req_signed_a & req_a[XLEN-1];
    assign req_sb       = req_signed_b & req_b[XLEN-1];
    assign req_a_abs    = req_sa ? (~req_a + 1'b1) : req_a;
    assign req_b_abs    = req_sb ? (~req_b + 1'b1) : req_b;
    assign req_b_zero   = (req_b == '0);

    // A divide by zero yields all ones as the quotient. The restoring loop
    // already produces all ones for a zero divisor, so the quotient is never
    // negated in that case. The remainder (|a|) takes the sign of a, which
    // gives back a itself.
    always_comb begin
        req_neg = 1'b0;
        if (!req_is_div) begin
            req_neg = req_sa ^ req_sb;
        end else if (req_funct3[1]) begin
            req_neg = req_sa;
        end else begin
            req_neg = (req_sa ^ req_sb) & ~req_b_zero;
        end
    end

`ifdef CPU6_MULDIV_EARLYOUT_EN
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    logic            eo_hit;
    logic [XLEN-1:0] eo_result;
    logic            eo_div0, eo_ovf, eo_mul0;

    assign eo_div0 = req_is_div & req_b_zero;
    assign eo_ovf  = req_is_div & ~req_funct3[0] &
                     (req_a == MIN_NEG) & (req_b == ALL_ONES);
    assign eo_mul0 = ~req_is_div & ((req_a == '0) | req_b_zero);
    assign eo_hit  = eo_div0 | eo_ovf | eo_mul0;

    always_comb begin
        eo_result = '0;
        if (eo_div0) begin
            eo_result = req_funct3[1] ? req_a : ALL_ONES;
        end else if (eo_ovf) begin
            eo_result = req_funct3[1] ? '0 : req_a;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Multiply step: add the multiplicand if the current multiplier bit is
    // set, then shift the {carry, hi, lo} pair right by one bit.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt;

    assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi_nxt = mul_sum[XLEN:1];
    assign mul_lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};

    // Restoring divide step: shift in the next dividend bit, then subtract
    // the divisor if it fits. Any remainder that survives is below the
    // divisor, so XLEN bits are enough for the difference.
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] div_hi_nxt, div_lo_nxt;

    assign div_shift  = {hi_q, lo_q[XLEN-1]};
    assign div_ge     = (div_shift >= {1'b0, b_q});
    assign div_diff   = div_shift[XLEN-1:0] - b_q;
    assign div_hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
    assign div_lo_nxt = {lo_q[XLEN-2:0], div_ge};

    // FIX-cycle sign correction and half selection.
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix;
    logic [XLEN-1:0]   fix_result;

    assign prod_raw = {hi_q, lo_q};
    assign prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    assign div_raw  = f3_q[1] ? hi_q : lo_q;
    assign div_fix  = neg_q ? (~div_raw + 1'b1) : div_raw;

    always_comb begin
        fix_result = '0;
        if (f3_q[2]) begin
            fix_result = div_fix;
        end else if (f3_q == F3_MUL) begin
            fix_result = prod_fix[XLEN-1:0];
        end else begin
            fix_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    f3_d    = req_funct3;
                    rd_d    = req_rd;
                    neg_d   = req_neg;
                    hi_d    = '0;
                    lo_d    = req_a_abs;
                    b_d     = req_b_abs;
                    cnt_d   = CNT_W'(XLEN - 1);
                    state_d = ST_BUSY;
`ifdef CPU6_MULDIV_EARLYOUT_EN
                    if (eo_hit) begin
                        result_d = eo_result;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (f3_q[2]) begin
                    hi_d = div_hi_nxt;
                    lo_d = div_lo_nxt;
                end else begin
                    hi_d = mul_hi_nxt;
                    lo_d = mul_lo_nxt;
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                result_d = fix_result;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect or exception overrides everything, including a
        // response being consumed in the same cycle.
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = (state_q == ST_IDLE) && !flush;
    assign resp_valid  = (state_q == ST_DONE);
    assign resp_result = result_q;
    assign resp_rd     = rd_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu6_muldiv.sv
// Directed bench for cpu6_muldiv (XLEN=32). Expected values are hand-computed
// RV32M results. Inputs change 1 time unit after the rising edge, and outputs
// are sampled at that same point.
module tb_cpu6_muldiv;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int LAT_FULL = XLEN + 2;
`ifdef CPU6_MULDIV_EARLYOUT_EN
  localparam int LAT_EO = 1;
`else
  localparam int LAT_EO = XLEN + 2;
`endif

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [RD_W-1:0] req_rd;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic [RD_W-1:0] resp_rd;
  logic            busy;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  cpu6_muldiv #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_rd     (resp_rd),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present a request and let it be accepted on the next edge
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  // cycle 1 is the cycle just after the accept edge
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int cyc;
    check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    start_op(f3, a, b, rd);
    wait_resp(cyc);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, resp_result, exp_res);
    check({tag, "_rd"}, 32'(resp_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_result"}, resp_result, exp_res);
      check({tag, "_hold_rd"}, 32'(resp_rd), 32'(rd));
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'b000;
    req_a      = '0;
    req_b      = '0;
    req_rd     = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", resp_result, 32'h0);
    check("rst_rd", 32'(resp_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // multiplies
    run_op("mul",     MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, LAT_FULL, 0);
    run_op("mulh",    MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, LAT_FULL, 0);
    run_op("mulhu",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, LAT_FULL, 0);
    run_op("mulhsu",  MULHSU, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, LAT_FULL, 0);
    run_op("mulh_m1", MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, LAT_FULL, 0);
    run_op("mulh_n2", MULH,   32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, LAT_FULL, 0);
    run_op("mul_zero", MUL,   32'd0,        32'd1234,     5'd9,  32'h00000000, LAT_EO,   0);

    // divides
    run_op("divu",    DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       LAT_FULL, 0);
    run_op("remu",    REMU,   32'd100,      32'd7,        5'd11, 32'd2,        LAT_FULL, 0);
    run_op("div_neg", DIV,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, LAT_FULL, 0);
    run_op("rem_neg", REM,    32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, LAT_FULL, 0);

    // divide by zero and signed overflow
    run_op("div_by0",  DIV,   32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, LAT_EO, 0);
    run_op("rem_by0",  REM,   32'd5,        32'd0,        5'd15, 32'd5,        LAT_EO, 0);
    run_op("divn_by0", DIV,   32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFF, LAT_EO, 0);
    run_op("remn_by0", REM,   32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFB, LAT_EO, 0);
    run_op("divu_by0", DIVU,  32'd9,        32'd0,        5'd18, 32'hFFFFFFFF, LAT_EO, 0);
    run_op("div_ovf",  DIV,   32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, LAT_EO, 0);
    run_op("rem_ovf",  REM,   32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, LAT_EO, 0);

    // back-pressure: hold resp_ready low for 3 cycles in DONE
    run_op("hold", DIVU, 32'd1000, 32'd10, 5'd21, 32'd100, LAT_FULL, 3);

    // flush in cycle 10 of BUSY with a competing request
    start_op(DIVU, 32'd50, 32'd3, 5'd22);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("flush_busy_before", 32'(busy), 32'd1);
    flush      = 1'b1;
    req_valid  = 1'b1;
    req_funct3 = MUL;
    req_a      = 32'd2;
    req_b      = 32'd3;
    req_rd     = 5'd23;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle", 32'(dbg_state), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_resp_valid", 32'(resp_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid || busy) seen++;
    end
    check("flush_no_resp", seen, 0);

    // flush and resp_ready together in DONE
    start_op(MUL, 32'd3, 32'd5, 5'd24);
    wait_resp(cyc);
    check("fr_result", resp_result, 32'd15);
    flush      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    resp_ready = 1'b0;
    check("fr_idle", 32'(busy), 32'd0);
    check("fr_valid", 32'(resp_valid), 32'd0);

    // reset in the middle of BUSY; resp_result still holds 15 from above
    start_op(MULHU, 32'h12345678, 32'h9ABCDEF0, 5'd25);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #1;
    reset = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(resp_valid), 32'd0);
    check("mrst_result", resp_result, 32'h0);
    check("mrst_rd", 32'(resp_rd), 32'd0);
    check("mrst_req_ready", 32'(req_ready), 32'd1);
    check("mrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // recovery after reset: 0x12345678 * 0x9ABCDEF0 = 0x0B00EA4E_242D2080
    run_op("post_rst", MULHU, 32'h12345678, 32'h9ABCDEF0, 5'd26, 32'h0B00EA4E, LAT_FULL, 0);
    run_op("post_rst_lo", MUL, 32'h12345678, 32'h9ABCDEF0, 5'd27, 32'h242D2080, LAT_FULL, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
